daq_pixel_capture: RTL and testbench
====================================

DAQ_PIXEL_CAPTURE -- requirements
Module: daq_pixel_capture

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth for all sensor-side inputs; legal range 2..4.
REQ-002 Parameter FIFO_DEPTH, default 16: output FIFO depth in 33-bit entries; power of two, minimum 4.
REQ-003 clk  input  1  system clock; frequency at least 4x pix_clk.
REQ-004 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 pix_clk  input  1  sensor pixel clock, asynchronous to clk.
REQ-006 pix_data  input  8  sensor pixel byte, valid at the pix_clk rising edge.
REQ-007 frame_valid  input  1  sensor frame-active level.
REQ-008 line_valid  input  1  sensor line-active level.
REQ-009 m_data  output  32  packed output word.
REQ-010 m_last  output  1  marks the frame trailer word.
REQ-011 m_valid  output  1  output word available.
REQ-012 m_ready  input  1  consumer accepts the word.
REQ-013 frame_cnt  output  16  count of completed frames.
REQ-014 overflow  output  1  sticky flag: a word was dropped.
REQ-015 clr_overflow  input  1  clears overflow.

Function
REQ-016 The block SHALL pass pix_clk, pix_data, frame_valid and line_valid through SYNC_STAGES flops each; the synced signals are pclk_s, data_s, fv_s and lv_s.
REQ-017 A pixel strobe SHALL occur in the clk cycle where pclk_s=1 and the previous pclk_s=0.
REQ-018 FSM states:
- IDLE: go to ARMED when fv_s=0.
- ARMED: go to ACTIVE on the fv_s 0->1 edge.
- ACTIVE: go to FLUSH on the fv_s 1->0 edge.
- FLUSH: go to TRAILER.
- TRAILER: go to ARMED.
REQ-019 In ACTIVE, each strobe with fv_s=1 and lv_s=1 SHALL capture data_s into byte lane byte_idx (lane 0 = bits [7:0]), then increment byte_idx modulo 4.
REQ-020 When the fourth byte is captured, the block SHALL write the word to the FIFO with last=0 in the next cycle.
REQ-021 In FLUSH, if byte_idx!=0 the block SHALL write the partial word with unused upper lanes zero and last=0, then reset byte_idx to 0.
REQ-022 In TRAILER, the block SHALL write {16'hFEED, frame_cnt} with last=1, then increment frame_cnt; frame_cnt wraps 0xFFFF->0x0000.
REQ-023 The FIFO SHALL be first-word-fall-through: m_valid = not empty; m_data and m_last come from the head entry.
REQ-024 A transfer SHALL occur when m_valid=1 and m_ready=1; m_data and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-025 Full SHALL be evaluated on the registered count. A write while full SHALL be dropped and SHALL set overflow, even when a pop occurs in the same cycle.
REQ-026 clr_overflow=1 SHALL clear overflow; when a set and a clear occur in the same cycle, the set SHALL win.
REQ-027 Strobes outside ACTIVE, or with lv_s=0, SHALL be ignored.
REQ-028 Input words SHALL enter the FIFO in capture order; total latency from strobe of the fourth byte to m_valid on an empty FIFO SHALL be 2 clk cycles.

Reset
REQ-029 On reset assertion:
- FSM goes to IDLE; byte_idx, FIFO pointers and count, frame_cnt and all synchronizer flops go to 0.
- m_valid=0, m_data=0, m_last=0, overflow=0.
REQ-030 On reset release mid-frame (fv_s=1), the block SHALL capture nothing until fv_s has been 0 and then risen again.

Configuration
REQ-031 Macro DAQ_CAPTURE_LINE_HDR_EN.
- Defined: in ACTIVE, each lv_s 0->1 edge SHALL first flush any partial word (as REQ-021), then write {16'hA5A5, line_idx}; line_idx counts 0,1,2,... and resets to 0 on each frame start.
- Undefined: no line headers; bytes SHALL pack contiguously across line boundaries.

Structure
REQ-032 Package daq_capture_pkg SHALL hold the FSM state encoding, TRAILER_TAG=16'hFEED and LINE_HDR_TAG=16'hA5A5.
REQ-033 The FIFO SHALL be a sub-module daq_sync_fifo (single clock, 33 bits wide, depth parameterized, exposes count).

Verification
REQ-034 Frame: 2 lines of 8 bytes, values 0x00..0x0F, m_ready=1 -> output 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, then 0xFEED0000 with m_last=1; frame_cnt=1.
REQ-035 Frame: 1 line of 6 bytes, values 0x00..0x05 -> output 0x03020100, 0x00000504, then 0xFEED0000 with m_last=1.
REQ-036 Reset released with frame_valid=1 mid-frame -> no output words; the next full frame is captured normally and frame_cnt=1 after it.
REQ-037 m_ready=0, FIFO_DEPTH=16, one frame of 80 bytes -> overflow=1; after m_ready=1, exactly 16 words are output, 0x03020100 through 0x3F3E3D3C, with no trailer.
REQ-038 overflow=1, then clr_overflow=1 in the same cycle as a dropped write -> overflow stays 1; clr_overflow=1 in the next cycle -> overflow=0.
REQ-039 With DAQ_CAPTURE_LINE_HDR_EN defined: 2 lines of 4 bytes, values 0x00..0x07 -> output 0xA5A50000, 0x03020100, 0xA5A50001, 0x07060504, then 0xFEED0000 with m_last=1.

Source files
------------

// File: rtl/daq_capture_pkg.sv
// Shared types and constants for the pixel capture block.
// Covers the capture FSM encoding and the tag values used in trailer and line-header words.
package daq_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_ACTIVE,
        ST_FLUSH,
        ST_TRAILER
    } cap_state_t;

    localparam logic [15:0] TRAILER_TAG  = 16'hFEED;
    localparam logic [15:0] LINE_HDR_TAG = 16'hA5A5;
    localparam int          ENTRY_W      = 33;

    function automatic logic [31:0] tag_word(input logic [15:0] tag, input logic [15:0] val);
        return {tag, val};
    endfunction

endpackage

// File: rtl/daq_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with an exposed occupancy count.
// Writes while full and reads while empty are ignored; the head reads as zero when the FIFO is empty.
module daq_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     sys_rst_n,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_wr_en && (r_count != FULL_CNT);
    assign w_pop  = i_rd_en && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/daq_pixel_capture.sv
// Captures a parallel pixel sensor bus into the clk domain, packs bytes into 32-bit words and queues
// them with a per-frame trailer. Define DAQ_CAPTURE_LINE_HDR_EN to emit a header word at each line start.
//
// state   | meaning
// IDLE    | after reset: let synchronizers settle, wait for fv_s low
// ARMED   | wait for frame start (fv_s rising)
// ACTIVE  | capture bytes on pixel strobes while lv_s is high
// FLUSH   | queue any partial word
// TRAILER | queue the frame trailer, advance frame_cnt
module daq_pixel_capture
    import daq_capture_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        sys_rst_n,
    input  logic        pix_clk,
    input  logic [7:0]  pix_data,
    input  logic        frame_valid,
    input  logic        line_valid,
    output logic [31:0] m_data,
    output logic        m_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [15:0] frame_cnt,
    output logic        overflow,
    input  logic        clr_overflow
);

    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT    = (AW+1)'(FIFO_DEPTH);
    localparam logic [2:0]  SETTLE_INIT = 3'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0]      r_sync_pclk;
    logic [SYNC_STAGES-1:0]      r_sync_fv;
    logic [SYNC_STAGES-1:0]      r_sync_lv;
    logic [SYNC_STAGES-1:0][7:0] r_sync_data;
    logic                        w_pclk_s, w_fv_s, w_lv_s;
    logic [7:0]                  w_data_s;
    logic                        r_pclk_prev, r_fv_prev;
    logic                        w_strobe, w_fv_rise, w_fv_fall;
    logic [2:0]                  r_settle_cnt;

    cap_state_t  r_state, w_state_nxt;
    logic [1:0]  r_byte_idx;
    logic [31:0] r_word;
    logic [15:0] r_frame_cnt;
    logic        r_wr_en, r_wr_last;
    logic [31:0] r_wr_data;
    logic        w_capture, w_wr_set, w_wr_last, w_idx_clr, w_frame_inc;
    logic [31:0] w_wr_data;
    logic        r_overflow;
    logic        w_full, w_fifo_empty;
    logic [AW:0] w_fifo_count;
    logic [ENTRY_W-1:0] w_fifo_rd;

`ifdef DAQ_CAPTURE_LINE_HDR_EN
    logic        r_lv_prev, w_lv_rise;
    logic        r_hdr_pend, w_hdr_pend_nxt;
    logic        w_line_clr, w_line_inc;
    logic [15:0] r_line_idx;
`endif

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync_pclk  <= '0;
            r_sync_fv    <= '0;
            r_sync_lv    <= '0;
            r_sync_data  <= '0;
            r_pclk_prev  <= 1'b0;
            r_fv_prev    <= 1'b0;
            r_settle_cnt <= SETTLE_INIT;
        end else begin
            r_sync_pclk <= {r_sync_pclk[SYNC_STAGES-2:0], pix_clk};
            r_sync_fv   <= {r_sync_fv[SYNC_STAGES-2:0], frame_valid};
            r_sync_lv   <= {r_sync_lv[SYNC_STAGES-2:0], line_valid};
            r_sync_data <= {r_sync_data[SYNC_STAGES-2:0], pix_data};
            r_pclk_prev <= w_pclk_s;
            r_fv_prev   <= w_fv_s;
            if (r_settle_cnt != 3'd0) r_settle_cnt <= r_settle_cnt - 3'd1;
        end
    end

    assign w_pclk_s  = r_sync_pclk[SYNC_STAGES-1];
    assign w_fv_s    = r_sync_fv[SYNC_STAGES-1];
    assign w_lv_s    = r_sync_lv[SYNC_STAGES-1];
    assign w_data_s  = r_sync_data[SYNC_STAGES-1];
    assign w_strobe  = w_pclk_s && !r_pclk_prev;
    assign w_fv_rise = w_fv_s && !r_fv_prev;
    assign w_fv_fall = !w_fv_s && r_fv_prev;
    assign w_full    = (w_fifo_count == FULL_CNT);

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_wr_set    = 1'b0;
        w_wr_data   = '0;
        w_wr_last   = 1'b0;
        w_idx_clr   = 1'b0;
        w_frame_inc = 1'b0;
`ifdef DAQ_CAPTURE_LINE_HDR_EN
        w_hdr_pend_nxt = 1'b0;
        w_line_clr     = 1'b0;
        w_line_inc     = 1'b0;
`endif
        unique case (r_state)
            // The settle count keeps a frame already in progress at reset release from looking like a fresh start.
            ST_IDLE: begin
                if (r_settle_cnt == 3'd0 && !w_fv_s) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_fv_rise) begin
                    w_state_nxt = ST_ACTIVE;
`ifdef DAQ_CAPTURE_LINE_HDR_EN
                    w_line_clr  = 1'b1;
`endif
                end
            end
            ST_ACTIVE: begin
                if (w_fv_fall) begin
                    w_state_nxt = ST_FLUSH;
`ifdef DAQ_CAPTURE_LINE_HDR_EN
                end else if (r_hdr_pend) begin
                    w_wr_set   = 1'b1;
                    w_wr_data  = tag_word(LINE_HDR_TAG, r_line_idx);
                    w_line_inc = 1'b1;
                end else if (w_lv_rise) begin
                    w_wr_set = 1'b1;
                    if (r_byte_idx != 2'd0) begin
                        w_wr_data      = r_word;
                        w_idx_clr      = 1'b1;
                        w_hdr_pend_nxt = 1'b1;
                    end else begin
                        w_wr_data  = tag_word(LINE_HDR_TAG, r_line_idx);
                        w_line_inc = 1'b1;
                    end
`endif
                end else if (w_strobe && w_fv_s && w_lv_s) begin
                    w_capture = 1'b1;
                    if (r_byte_idx == 2'd3) begin
                        w_wr_set  = 1'b1;
                        w_wr_data = {w_data_s, r_word[23:0]};
                    end
                end
            end
            ST_FLUSH: begin
                w_state_nxt = ST_TRAILER;
                if (r_byte_idx != 2'd0) begin
                    w_wr_set  = 1'b1;
                    w_wr_data = r_word;
                    w_idx_clr = 1'b1;
                end
            end
            ST_TRAILER: begin
                w_state_nxt = ST_ARMED;
                w_wr_set    = 1'b1;
                w_wr_data   = tag_word(TRAILER_TAG, r_frame_cnt);
                w_wr_last   = 1'b1;
                w_frame_inc = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_byte_idx  <= 2'd0;
            r_word      <= '0;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
            r_wr_last   <= 1'b0;
            r_frame_cnt <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_idx_clr)      r_byte_idx <= 2'd0;
            else if (w_capture) r_byte_idx <= r_byte_idx + 2'd1;
            // Lane 0 starts a fresh word so a partial flush always carries zero upper lanes.
            if (w_capture) begin
                if (r_byte_idx == 2'd0) r_word <= {24'h0, w_data_s};
                else                    r_word[{r_byte_idx, 3'b000} +: 8] <= w_data_s;
            end
            r_wr_en   <= w_wr_set;
            r_wr_data <= w_wr_data;
            r_wr_last <= w_wr_last;
            if (w_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (r_wr_en && w_full) r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

`ifdef DAQ_CAPTURE_LINE_HDR_EN
    assign w_lv_rise = w_lv_s && !r_lv_prev;

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_lv_prev  <= 1'b0;
            r_hdr_pend <= 1'b0;
            r_line_idx <= '0;
        end else begin
            r_lv_prev  <= w_lv_s;
            r_hdr_pend <= w_hdr_pend_nxt;
            if (w_line_clr)      r_line_idx <= '0;
            else if (w_line_inc) r_line_idx <= r_line_idx + 16'd1;
        end
    end
`endif

    daq_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .sys_rst_n (sys_rst_n),
        .i_wr_en   (r_wr_en),
        .i_wr_data ({r_wr_last, r_wr_data}),
        .i_rd_en   (m_ready),
        .o_rd_data (w_fifo_rd),
        .o_empty   (w_fifo_empty),
        .o_count   (w_fifo_count)
    );

    assign m_data    = w_fifo_rd[31:0];
    assign m_last    = w_fifo_rd[32];
    assign m_valid   = !w_fifo_empty;
    assign frame_cnt = r_frame_cnt;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_daq_pixel_capture.sv
// Directed bench for daq_pixel_capture: vector table of frames plus hand-written sequences for
// latency, mid-frame reset, FIFO overflow and overflow clear priority.
module tb_daq_pixel_capture;

    localparam int SYNC  = 2;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        sys_rst_n;
    logic        pix_clk;
    logic [7:0]  pix_data;
    logic        frame_valid;
    logic        line_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] frame_cnt;
    logic        overflow;
    logic        clr_overflow;

    always #5 clk = ~clk;

    daq_pixel_capture #(.SYNC_STAGES(SYNC), .FIFO_DEPTH(DEPTH)) dut (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .pix_clk      (pix_clk),
        .pix_data     (pix_data),
        .frame_valid  (frame_valid),
        .line_valid   (line_valid),
        .m_data       (m_data),
        .m_last       (m_last),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .frame_cnt    (frame_cnt),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    typedef struct packed {
        logic [7:0]       n_lines;
        logic [7:0]       bpl;
        logic [7:0]       start;
        logic [3:0]       n_words;
        logic [5:0][31:0] words;
    } vec_t;

    vec_t        vecs [3];
    logic [32:0] q_out [$];
    int          n_checks = 0;
    int          n_errors = 0;

    always @(negedge clk) begin
        if (m_valid && m_ready) q_out.push_back({m_last, m_data});
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic pop_chk(input string name, input logic [32:0] exp);
        logic [32:0] w;
        if (q_out.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: got no word want 0x%0h", name, exp);
        end else begin
            w = q_out.pop_front();
            chk(name, 64'(w), 64'(exp));
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        pix_data = v;
        tick(4);
        pix_clk = 1'b1;
        tick(4);
        pix_clk = 1'b0;
    endtask

    task automatic send_frame(input int nl, input int bpl, input int start);
        frame_valid = 1'b1;
        tick(8);
        for (int l = 0; l < nl; l++) begin
            line_valid = 1'b1;
            for (int b = 0; b < bpl; b++) send_byte(8'(start + l * bpl + b));
            line_valid = 1'b0;
            tick(8);
        end
        frame_valid = 1'b0;
        tick(20);
    endtask

    task automatic run_vec(input int v, input logic [15:0] fc);
        q_out.delete();
        send_frame(int'(vecs[v].n_lines), int'(vecs[v].bpl), int'(vecs[v].start));
        tick(10);
        for (int w = 0; w < int'(vecs[v].n_words); w++)
            pop_chk($sformatf("vec%0d_word%0d", v, w), {1'b0, vecs[v].words[w]});
        pop_chk($sformatf("vec%0d_trailer", v), {1'b1, 16'hFEED, fc});
        chk($sformatf("vec%0d_extra_words", v), 64'(q_out.size()), 64'd0);
        chk($sformatf("vec%0d_frame_cnt", v), 64'(frame_cnt), 64'(fc + 16'd1));
    endtask

    logic [31:0] exp_w;
    logic        seen;

    initial begin
`ifdef DAQ_CAPTURE_LINE_HDR_EN
        vecs[0].n_lines = 8'd2; vecs[0].bpl = 8'd8; vecs[0].start = 8'h00; vecs[0].n_words = 4'd6;
        vecs[0].words   = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[0].words[0] = 32'hA5A50000; vecs[0].words[1] = 32'h03020100; vecs[0].words[2] = 32'h07060504;
        vecs[0].words[3] = 32'hA5A50001; vecs[0].words[4] = 32'h0B0A0908; vecs[0].words[5] = 32'h0F0E0D0C;
        vecs[1].n_lines = 8'd1; vecs[1].bpl = 8'd6; vecs[1].start = 8'h00; vecs[1].n_words = 4'd3;
        vecs[1].words   = '0;
        vecs[1].words[0] = 32'hA5A50000; vecs[1].words[1] = 32'h03020100; vecs[1].words[2] = 32'h00000504;
        vecs[2].n_lines = 8'd2; vecs[2].bpl = 8'd4; vecs[2].start = 8'h00; vecs[2].n_words = 4'd4;
        vecs[2].words   = '0;
        vecs[2].words[0] = 32'hA5A50000; vecs[2].words[1] = 32'h03020100;
        vecs[2].words[2] = 32'hA5A50001; vecs[2].words[3] = 32'h07060504;
`else
        vecs[0].n_lines = 8'd2; vecs[0].bpl = 8'd8; vecs[0].start = 8'h00; vecs[0].n_words = 4'd4;
        vecs[0].words   = '0;
        vecs[0].words[0] = 32'h03020100; vecs[0].words[1] = 32'h07060504;
        vecs[0].words[2] = 32'h0B0A0908; vecs[0].words[3] = 32'h0F0E0D0C;
        vecs[1].n_lines = 8'd1; vecs[1].bpl = 8'd6; vecs[1].start = 8'h00; vecs[1].n_words = 4'd2;
        vecs[1].words   = '0;
        vecs[1].words[0] = 32'h03020100; vecs[1].words[1] = 32'h00000504;
        // Bytes pack straight across the line boundary.
        vecs[2].n_lines = 8'd2; vecs[2].bpl = 8'd3; vecs[2].start = 8'h20; vecs[2].n_words = 4'd2;
        vecs[2].words   = '0;
        vecs[2].words[0] = 32'h23222120; vecs[2].words[1] = 32'h00002524;
`endif

        sys_rst_n    = 1'b0;
        pix_clk      = 1'b0;
        pix_data     = 8'h00;
        frame_valid  = 1'b0;
        line_valid   = 1'b0;
        m_ready      = 1'b1;
        clr_overflow = 1'b0;
        tick(3);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        sys_rst_n = 1'b1;
        tick(10);

        for (int v = 0; v < 3; v++) run_vec(v, 16'(v));

        // Fourth byte strobe to m_valid on an empty FIFO.
        q_out.delete();
        m_ready     = 1'b0;
        frame_valid = 1'b1;
        tick(8);
        line_valid = 1'b1;
        send_byte(8'h10);
        send_byte(8'h11);
        send_byte(8'h12);
        pix_data = 8'h13;
        tick(4);
        pix_clk = 1'b1;
        repeat (SYNC + 1) @(posedge clk);
        @(negedge clk);
`ifndef DAQ_CAPTURE_LINE_HDR_EN
        chk("latency_early", 64'(m_valid), 64'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        chk("latency_valid", 64'(m_valid), 64'd1);
        tick(1);
        tick(2);
        pix_clk    = 1'b0;
        line_valid = 1'b0;
        tick(8);
        frame_valid = 1'b0;
        tick(20);
        m_ready = 1'b1;
        tick(20);
`ifdef DAQ_CAPTURE_LINE_HDR_EN
        pop_chk("lat_hdr", {1'b0, 32'hA5A50000});
`endif
        pop_chk("lat_word", {1'b0, 32'h13121110});
        pop_chk("lat_trailer", {1'b1, 32'hFEED0003});
        chk("lat_frame_cnt", 64'(frame_cnt), 64'd4);

        // Reset released in the middle of a frame: that frame must be ignored entirely.
        q_out.delete();
        frame_valid = 1'b1;
        line_valid  = 1'b1;
        sys_rst_n   = 1'b0;
        tick(3);
        sys_rst_n = 1'b1;
        tick(2);
        for (int b = 0; b < 8; b++) send_byte(8'(8'h40 + b));
        line_valid = 1'b0;
        tick(8);
        frame_valid = 1'b0;
        tick(30);
        chk("midrst_no_words", 64'(q_out.size()), 64'd0);
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        run_vec(0, 16'd0);

        // 80 bytes into a stalled 16-entry FIFO.
        q_out.delete();
        m_ready = 1'b0;
        send_frame(1, 80, 0);
        tick(10);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_head_valid", 64'(m_valid), 64'd1);
`ifdef DAQ_CAPTURE_LINE_HDR_EN
        chk("ovf_head_data", 64'(m_data), 64'hA5A50000);
`else
        chk("ovf_head_data", 64'(m_data), 64'h03020100);
`endif
        chk("ovf_head_last", 64'(m_last), 64'd0);
        m_ready = 1'b1;
        tick(40);
        chk("ovf_word_count", 64'(q_out.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
`ifdef DAQ_CAPTURE_LINE_HDR_EN
            if (i == 0) exp_w = 32'hA5A50000;
            else exp_w = {8'(4*(i-1)+3), 8'(4*(i-1)+2), 8'(4*(i-1)+1), 8'(4*(i-1))};
`else
            exp_w = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
`endif
            pop_chk($sformatf("ovf_word%0d", i), {1'b0, exp_w});
        end
        chk("ovf_sticky", 64'(overflow), 64'd1);
        chk("ovf_frame_cnt", 64'(frame_cnt), 64'd2);

        clr_overflow = 1'b1;
        tick(1);
        clr_overflow = 1'b0;
        chk("ovf_clear", 64'(overflow), 64'd0);

        // Fill exactly, then hold clr_overflow while the trailer write is dropped: the set must win.
        q_out.delete();
        m_ready     = 1'b0;
        frame_valid = 1'b1;
        tick(8);
        line_valid = 1'b1;
        for (int b = 0; b < 64; b++) send_byte(8'(b));
        line_valid = 1'b0;
        tick(8);
        clr_overflow = 1'b1;
        tick(1);
        frame_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (overflow) seen = 1'b1;
        end
        chk("clr_vs_set_seen", 64'(seen), 64'd1);
        chk("clr_next_cycle", 64'(overflow), 64'd0);
        clr_overflow = 1'b0;
        tick(5);
        chk("clr_stays", 64'(overflow), 64'd0);
        m_ready = 1'b1;
        tick(40);
        chk("full_word_count", 64'(q_out.size()), 64'd16);
`ifdef DAQ_CAPTURE_LINE_HDR_EN
        pop_chk("full_first", {1'b0, 32'hA5A50000});
`else
        pop_chk("full_first", {1'b0, 32'h03020100});
`endif
        chk("full_frame_cnt", 64'(frame_cnt), 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
